// File: rtl/comparador_escalonador_pkg.sv
// Shared definitions for the time-shared equality comparator slice.
// Holds the operand code width and the scheduler FSM state encoding.
// No ports; imported by every module of the block.
package comparador_escalonador_pkg;

   localparam int CODE_W = 3;

   // 2'd3 is not a legal state; the FSM recovers from it to IDLE.
   typedef enum logic [1:0] {
      IDLE = 2'd0,
      CMP  = 2'd1,
      RESP = 2'd2
   } state_t;

endpackage

// File: rtl/comparador_igualdade_3b.sv
// Purpose: combinational equality of two CODE_W-bit codes; latency 0; no backpressure.
// Ports: a_i, b_i - codes to compare; eq_o - 1 when a_i == b_i.
// Instantiated once and shared by all requester channels through the scheduler.
module comparador_igualdade_3b
   import comparador_escalonador_pkg::*;
(
   input  logic [CODE_W-1:0] a_i,
   input  logic [CODE_W-1:0] b_i,
   output logic              eq_o
);

   assign eq_o = (a_i == b_i);

endmodule

// File: rtl/comparador_escalonador.sv
// Purpose: round-robin time-sharing of one equality comparator among N channels, with per-channel mismatch alarms.
// Latency: request sampled in IDLE at edge t -> one-hot ack plus match during cycle t+2; one compare per 3 cycles.
// Backpressure: requesters hold req/codes until ack; operands are latched at grant so later changes are ignored.
// Ports: clk, reset (sync, active-high); req[N], code_a/code_b[3N] (channel i at [3i+2:3i]), alarm_clr[N];
//        ack[N] one-hot pulse, match (valid with ack, else 0), busy (state != IDLE), alarm[N] registered.
module comparador_escalonador
   import comparador_escalonador_pkg::*;
#(
   parameter int N          = 4,   // requester channels, 2..8
   parameter int MISS_LIMIT = 3,   // consecutive mismatches that raise alarm, 1..15
   parameter int CW         = 4    // counter width, 2**CW > MISS_LIMIT
)
(
   input  logic                clk,
   input  logic                reset,
   input  logic [N-1:0]        req,
   input  logic [CODE_W*N-1:0] code_a,
   input  logic [CODE_W*N-1:0] code_b,
   input  logic [N-1:0]        alarm_clr,
   output logic [N-1:0]        ack,
   output logic                match,
   output logic                busy,
   output logic [N-1:0]        alarm
);

   localparam int IW = $clog2(N);

   state_t            state_q, state_d;
   logic [IW-1:0]     idx_q, idx_d;
   logic [IW-1:0]     rr_q, rr_d;
   logic [CODE_W-1:0] a_l_q, a_l_d;
   logic [CODE_W-1:0] b_l_q, b_l_d;
   logic              match_r_q, match_r_d;
   logic [CW-1:0]     cnt_q [N];
   logic [CW-1:0]     cnt_d [N];
   logic [N-1:0]      alarm_q, alarm_d;

   logic              eq_w;
   logic              grant_vld;
   logic [IW-1:0]     grant_idx;
   logic [IW-1:0]     rr_next;

   comparador_igualdade_3b u_eq (
      .a_i  (a_l_q),
      .b_i  (b_l_q),
      .eq_o (eq_w)
   );

   // Round-robin search: candidates rr_q, rr_q+1, ... wrapped modulo N.
   // One extra bit on the sum keeps the wrap correct for non power-of-two N.
   always_comb begin
      logic [IW:0] sum_v;
      sum_v     = '0;
      grant_vld = 1'b0;
      grant_idx = '0;
      for (int i = 0; i < N; i++) begin
         sum_v = {1'b0, rr_q} + (IW+1)'(i);
         if (sum_v >= (IW+1)'(N)) begin
            sum_v = sum_v - (IW+1)'(N);
         end
         if (!grant_vld && req[sum_v[IW-1:0]]) begin
            grant_vld = 1'b1;
            grant_idx = sum_v[IW-1:0];
         end
      end
   end

   // Pointer moves to the channel just after the one being served.
   always_comb begin
      logic [IW:0] nxt_v;
      nxt_v = {1'b0, idx_q} + (IW+1)'(1);
      if (nxt_v >= (IW+1)'(N)) begin
         nxt_v = '0;
      end
      rr_next = nxt_v[IW-1:0];
   end

   // Scheduler FSM: IDLE (grant + latch) -> CMP (compare) -> RESP (ack).
   always_comb begin
      state_d   = state_q;
      idx_d     = idx_q;
      rr_d      = rr_q;
      a_l_d     = a_l_q;
      b_l_d     = b_l_q;
      match_r_d = match_r_q;
      ack       = '0;
      match     = 1'b0;
      busy      = 1'b1;
      case (state_q)
         IDLE: begin
            busy = 1'b0;
            if (grant_vld) begin
               idx_d   = grant_idx;
               a_l_d   = code_a[int'(grant_idx)*CODE_W +: CODE_W];
               b_l_d   = code_b[int'(grant_idx)*CODE_W +: CODE_W];
               state_d = CMP;
            end
         end
         CMP: begin
            match_r_d = eq_w;
            state_d   = RESP;
         end
         RESP: begin
            ack[idx_q] = 1'b1;
            match      = match_r_q;
            rr_d       = rr_next;
            state_d    = IDLE;
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   // Mismatch counters: only the served channel moves, and only in CMP.
   // alarm_clr is applied last so it beats a same-cycle CMP update.
   // alarm is taken from the next-state count so it rises with the counter,
   // i.e. it is already high during the RESP cycle of the limiting mismatch.
   always_comb begin
      for (int i = 0; i < N; i++) begin
         cnt_d[i] = cnt_q[i];
         if (state_q == CMP && idx_q == IW'(i)) begin
            if (eq_w) begin
               cnt_d[i] = '0;
            end else if (cnt_q[i] >= CW'(MISS_LIMIT)) begin
               cnt_d[i] = CW'(MISS_LIMIT);
            end else begin
               cnt_d[i] = cnt_q[i] + CW'(1);
            end
         end
         if (alarm_clr[i]) begin
            cnt_d[i] = '0;
         end
         alarm_d[i] = (cnt_d[i] == CW'(MISS_LIMIT));
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q   <= IDLE;
         idx_q     <= '0;
         rr_q      <= '0;
         a_l_q     <= '0;
         b_l_q     <= '0;
         match_r_q <= 1'b0;
         cnt_q     <= '{default: '0};
         alarm_q   <= '0;
      end else begin
         state_q   <= state_d;
         idx_q     <= idx_d;
         rr_q      <= rr_d;
         a_l_q     <= a_l_d;
         b_l_q     <= b_l_d;
         match_r_q <= match_r_d;
         cnt_q     <= cnt_d;
         alarm_q   <= alarm_d;
      end
   end

   assign alarm = alarm_q;

endmodule
